// File: rtl/alu_pkg.sv
// Shared ALU encodings and FSM states. The ALU-control decoder and the
// multi-cycle ALU both import this package.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_SLL  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_XOR  = 4'b0110,
        ALU_SRL  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SRA  = 4'b1111
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } alu_state_t;

    localparam logic SHIFT_LEFT  = 1'b0;
    localparam logic SHIFT_RIGHT = 1'b1;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Request/response bundle for alu_mc: valid/ready request with operands,
// valid/ready response with result and flags.
interface alu_mc_if #(parameter int WIDTH = 32);

    logic             in_valid;
    logic             in_ready;
    logic [3:0]       alu_control;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;

    modport master (
        output in_valid, alu_control, src_a, src_b, out_ready,
        input  in_ready, out_valid, result, zero, illegal
    );

    modport slave (
        input  in_valid, alu_control, src_a, src_b, out_ready,
        output in_ready, out_valid, result, zero, illegal
    );

endinterface

// File: rtl/alu_mc_serial_shift.sv
// One-bit-per-cycle shifter. data_out is the accumulator after the next
// shift step, so the owner can capture the final value on the edge cnt hits 0.
module alu_serial_shift #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dir,
    input  logic             arith,
    input  logic [WIDTH-1:0] data_in,
    input  logic [SHW-1:0]   amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);
    import alu_pkg::*;

    logic [WIDTH-1:0] r_acc;
    logic [SHW-1:0]   r_cnt;
    logic             r_dir;
    logic             r_arith;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_next = r_acc;
        if (r_dir == SHIFT_LEFT)
            w_next = {r_acc[WIDTH-2:0], 1'b0};
        else
            w_next = {(r_arith & r_acc[WIDTH-1]), r_acc[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc   <= '0;
            r_cnt   <= '0;
            r_dir   <= SHIFT_LEFT;
            r_arith <= 1'b0;
        end else if (load) begin
            r_acc   <= data_in;
            r_cnt   <= amount;
            r_dir   <= dir;
            r_arith <= arith;
        end else if (r_cnt != '0) begin
            r_acc <= w_next;
            r_cnt <= r_cnt - SHW'(1);
        end
    end

    assign busy     = (r_cnt != '0);
    assign done     = (r_cnt == SHW'(1));
    assign data_out = w_next;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle integer ALU: single-cycle logic/arithmetic, serial shifts,
// registered result/zero/illegal held until the consumer takes it.
module alu_mc #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset_n,
    alu_mc_if.slave  bus
);
    import alu_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    alu_state_t       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_illegal;

    logic [WIDTH-1:0] w_res;
    logic             w_legal;
    logic [SHW-1:0]   w_amt;
    logic             w_shift_go;
    logic             w_cap;
    logic             w_sh_load;
    logic             w_sh_fin;
    logic             w_sh_busy;
    logic             w_sh_done;
    logic [WIDTH-1:0] w_sh_data;

    assign w_amt      = bus.src_b[SHW-1:0];
    assign w_shift_go = is_shift(bus.alu_control) && (w_amt != '0);

    // Single-cycle datapath; shifts by zero pass src_a through unchanged.
    always_comb begin
        w_res   = '0;
        w_legal = 1'b1;
        case (bus.alu_control)
            ALU_ADD:  w_res = bus.src_a + bus.src_b;
            ALU_SUB:  w_res = bus.src_a - bus.src_b;
            ALU_AND:  w_res = bus.src_a & bus.src_b;
            ALU_OR:   w_res = bus.src_a | bus.src_b;
            ALU_XOR:  w_res = bus.src_a ^ bus.src_b;
            ALU_SLT:  w_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
            ALU_SLTU: w_res = {{(WIDTH-1){1'b0}}, (bus.src_a < bus.src_b)};
            ALU_SLL, ALU_SRL, ALU_SRA: w_res = bus.src_a;
            default:  w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cap       = 1'b0;
        w_sh_load   = 1'b0;
        w_sh_fin    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.in_valid) begin
                    if (w_shift_go) begin
                        w_sh_load   = 1'b1;
                        w_state_nxt = S_SHIFT;
                    end else begin
                        w_cap       = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                if (w_sh_done || !w_sh_busy) begin
                    w_sh_fin    = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    alu_serial_shift #(.WIDTH(WIDTH), .SHW(SHW)) u_shift (
        .clk      (clk),
        .rst_n    (reset_n),
        .load     (w_sh_load),
        .dir      ((bus.alu_control == ALU_SLL) ? SHIFT_LEFT : SHIFT_RIGHT),
        .arith    (bus.alu_control == ALU_SRA),
        .data_in  (bus.src_a),
        .amount   (w_amt),
        .busy     (w_sh_busy),
        .done     (w_sh_done),
        .data_out (w_sh_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_cap) begin
            r_result  <= w_res;
            r_zero    <= (w_res == '0);
            r_illegal <= ~w_legal;
        end else if (w_sh_fin) begin
            r_result  <= w_sh_data;
            r_zero    <= (w_sh_data == '0);
            r_illegal <= 1'b0;
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.illegal   = r_illegal;

endmodule
